// File: rtl/neo_video_pkg.sv
// Shared definitions for the Neo video output path: colour word layout,
// CPU arbiter state encoding and the colour expansion helpers.
package neo_video_pkg;

    localparam int COL_DARK = 15;
    localparam int COL_R0   = 14;
    localparam int COL_G0   = 13;
    localparam int COL_B0   = 12;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_ACK  = 2'd2;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    // The inverted dark bit becomes the 6th bit; the top two bits are
    // replicated into the low end so full scale reaches 8'hFF.
    function automatic logic [7:0] col5_to_8(input logic [4:0] c5, input logic dark);
        logic [5:0] v6;
        v6 = {c5, ~dark};
        return {v6, v6[5:4]};
    endfunction

    function automatic rgb_t decode_word(input logic [15:0] word, input logic shadow);
        rgb_t p;
        p.r = col5_to_8({word[11:8], word[COL_R0]}, word[COL_DARK]);
        p.g = col5_to_8({word[7:4],  word[COL_G0]}, word[COL_DARK]);
        p.b = col5_to_8({word[3:0],  word[COL_B0]}, word[COL_DARK]);
        if (shadow) begin
            p.r = p.r >> 1;
            p.g = p.g >> 1;
            p.b = p.b >> 1;
        end
        return p;
    endfunction

endpackage

// File: rtl/neo_palram.sv
// Two-bank palette RAM: single read/write port, per-byte write enables,
// registered read data (read-before-write), intended to map onto block RAM.
module neo_palram #(
    parameter int AW = 13
) (
    input  logic          CLK,
    input  logic [AW-1:0] addr,
    input  logic [1:0]    we,
    input  logic [15:0]   din,
    output logic [15:0]   dout
);

    logic [15:0] mem [0:(1<<AW)-1];

    // NOTE: the array and its read register carry no reset; a reset term
    // would stop the tools from mapping this onto a block RAM.
    always_ff @(posedge CLK) begin
        if (we[0]) mem[addr][7:0]  <= din[7:0];
        if (we[1]) mem[addr][15:8] <= din[15:8];
        dout <= mem[addr];
    end

endmodule

// File: rtl/neo_palette_out.sv
// Final video stage: palette lookup, colour decode with dark/shadow/blank,
// and arbitration of the single palette RAM port between video and the 68k.
module neo_palette_out
    import neo_video_pkg::*;
#(
    parameter int RAM_AW = 13,
    parameter int OUT_W  = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             CE_PIX,
    input  logic [11:0]      PA,
    input  logic             PALBNK,
    input  logic             SHADOW,
    input  logic             HBLANK,
    input  logic             VBLANK,
    input  logic             CPU_REQ,
    input  logic             CPU_WE,
    input  logic [11:0]      CPU_ADDR,
    input  logic [1:0]       CPU_BE,
    input  logic [15:0]      CPU_DIN,
    output logic [15:0]      CPU_DOUT,
    output logic             CPU_ACK,
    output logic [OUT_W-1:0] R,
    output logic [OUT_W-1:0] G,
    output logic [OUT_W-1:0] B,
    output logic             DE
);

    logic [1:0]        state;
    logic              cpu_issue;
    logic [RAM_AW-1:0] ram_addr;
    logic [1:0]        ram_we;
    logic [15:0]       ram_q;

    logic              vid_cap;
    logic [15:0]       vid_q;
    logic              shadow_d;
    logic              hblank_d;
    logic              vblank_d;
    rgb_t              pix_rgb;

    // The video slot owns the port whenever CE_PIX is high; the CPU only
    // issues in an idle, non-pixel cycle.
    assign cpu_issue = (state == ST_IDLE) && CPU_REQ && !CE_PIX;

    // NOTE: every signal driven here gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    always_comb begin
        ram_addr = {PALBNK, CPU_ADDR};
        ram_we   = 2'b00;
        if (CE_PIX) begin
            ram_addr = {PALBNK, PA};
        end else if (cpu_issue && CPU_WE) begin
            ram_we = CPU_BE;
        end
    end

    neo_palram #(
        .AW (RAM_AW)
    ) u_palram (
        .CLK  (CLK),
        .addr (ram_addr),
        .we   (ram_we),
        .din  (CPU_DIN),
        .dout (ram_q)
    );

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state    <= ST_IDLE;
            CPU_DOUT <= 16'h0000;
        end else begin
            case (state)
                ST_IDLE: if (cpu_issue) state <= ST_WAIT;
                ST_WAIT: begin
                    if (!CPU_WE) CPU_DOUT <= ram_q;
                    state <= ST_ACK;
                end
                ST_ACK:  state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign CPU_ACK = (state == ST_ACK);

    // A CPU issue in the capture cycle only changes ram_q at the following
    // edge, so vid_q always takes the video word.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            vid_cap <= 1'b0;
            vid_q   <= 16'h0000;
        end else begin
            vid_cap <= CE_PIX;
            if (vid_cap) vid_q <= ram_q;
        end
    end

    always_comb begin
        pix_rgb = decode_word(vid_q, shadow_d);
    end

    // Flags sampled with PA are consumed one pixel later, together with the
    // word they belong to.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            shadow_d <= 1'b0;
            hblank_d <= 1'b0;
            vblank_d <= 1'b0;
            R        <= '0;
            G        <= '0;
            B        <= '0;
            DE       <= 1'b0;
        end else if (CE_PIX) begin
            shadow_d <= SHADOW;
            hblank_d <= HBLANK;
            vblank_d <= VBLANK;
            if (hblank_d || vblank_d) begin
                R  <= '0;
                G  <= '0;
                B  <= '0;
                DE <= 1'b0;
            end else begin
                R  <= pix_rgb.r;
                G  <= pix_rgb.g;
                B  <= pix_rgb.b;
                DE <= 1'b1;
            end
        end
    end

endmodule
